// File: rtl/axi4_lite_interconnect_m2s1.sv
// axi4_lite_interconnect_m2s1: two AXI4-Lite masters sharing one slave, with
// independent round-robin arbitration and FSMs on the write and read paths.
module axi4_lite_interconnect_m2s1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      m0_AWVALID,
    input  logic [ADDR_WIDTH-1:0]     m0_AWADDR,
    output logic                      m0_AWREADY,
    input  logic                      m0_WVALID,
    input  logic [DATA_WIDTH-1:0]     m0_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   m0_WSTRB,
    output logic                      m0_WREADY,
    input  logic                      m0_BREADY,
    output logic                      m0_BVALID,
    output logic [1:0]                m0_BRESP,
    input  logic                      m0_ARVALID,
    input  logic [ADDR_WIDTH-1:0]     m0_ARADDR,
    output logic                      m0_ARREADY,
    input  logic                      m0_RREADY,
    output logic                      m0_RVALID,
    output logic [1:0]                m0_RRESP,
    output logic [DATA_WIDTH-1:0]     m0_RDATA,
    input  logic                      m1_AWVALID,
    input  logic [ADDR_WIDTH-1:0]     m1_AWADDR,
    output logic                      m1_AWREADY,
    input  logic                      m1_WVALID,
    input  logic [DATA_WIDTH-1:0]     m1_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   m1_WSTRB,
    output logic                      m1_WREADY,
    input  logic                      m1_BREADY,
    output logic                      m1_BVALID,
    output logic [1:0]                m1_BRESP,
    input  logic                      m1_ARVALID,
    input  logic [ADDR_WIDTH-1:0]     m1_ARADDR,
    output logic                      m1_ARREADY,
    input  logic                      m1_RREADY,
    output logic                      m1_RVALID,
    output logic [1:0]                m1_RRESP,
    output logic [DATA_WIDTH-1:0]     m1_RDATA,
    output logic                      s0_AWVALID,
    output logic [ADDR_WIDTH-1:0]     s0_AWADDR,
    input  logic                      s0_AWREADY,
    output logic                      s0_WVALID,
    output logic [DATA_WIDTH-1:0]     s0_WDATA,
    output logic [DATA_WIDTH/8-1:0]   s0_WSTRB,
    input  logic                      s0_WREADY,
    output logic                      s0_BREADY,
    input  logic                      s0_BVALID,
    input  logic [1:0]                s0_BRESP,
    output logic                      s0_ARVALID,
    output logic [ADDR_WIDTH-1:0]     s0_ARADDR,
    input  logic                      s0_ARREADY,
    output logic                      s0_RREADY,
    input  logic                      s0_RVALID,
    input  logic [1:0]                s0_RRESP,
    input  logic [DATA_WIDTH-1:0]     s0_RDATA
);
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic    wgrant_q, wgrant_d, wprio_q, wprio_d;
    logic    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic    rgrant_q, rgrant_d, rprio_q, rprio_d;
    logic    w_xfer, w_resp, r_addr, r_data;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wstate_q  <= W_IDLE;
            wgrant_q  <= 1'b0;
            wprio_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rstate_q  <= R_IDLE;
            rgrant_q  <= 1'b0;
            rprio_q   <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            wgrant_q  <= wgrant_d;
            wprio_q   <= wprio_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rstate_q  <= rstate_d;
            rgrant_q  <= rgrant_d;
            rprio_q   <= rprio_d;
        end
    end

    // Handshake flags only move in W_XFER because s0 VALIDs are gated to it.
    always_comb begin
        wstate_d  = wstate_q;
        wgrant_d  = wgrant_q;
        wprio_d   = wprio_q;
        aw_done_d = aw_done_q | (s0_AWVALID & s0_AWREADY);
        w_done_d  = w_done_q | (s0_WVALID & s0_WREADY);
        case (wstate_q)
            W_IDLE: if (m0_AWVALID | m1_AWVALID) begin
                wstate_d = W_XFER;
                wgrant_d = (m0_AWVALID & m1_AWVALID) ? wprio_q : m1_AWVALID;
            end
            W_XFER: if (aw_done_d & w_done_d) wstate_d = W_RESP;
            W_RESP: if (s0_BVALID & s0_BREADY) begin
                wstate_d  = W_IDLE;
                wprio_d   = ~wgrant_q;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        w_xfer     = wstate_q == W_XFER;
        w_resp     = wstate_q == W_RESP;
        s0_AWVALID = w_xfer & ~aw_done_q & (wgrant_q ? m1_AWVALID : m0_AWVALID);
        s0_AWADDR  = w_xfer ? (wgrant_q ? m1_AWADDR : m0_AWADDR) : '0;
        s0_WVALID  = w_xfer & ~w_done_q & (wgrant_q ? m1_WVALID : m0_WVALID);
        s0_WDATA   = w_xfer ? (wgrant_q ? m1_WDATA : m0_WDATA) : '0;
        s0_WSTRB   = w_xfer ? (wgrant_q ? m1_WSTRB : m0_WSTRB) : '0;
        s0_BREADY  = w_resp & (wgrant_q ? m1_BREADY : m0_BREADY);
        m0_AWREADY = w_xfer & ~wgrant_q & ~aw_done_q & s0_AWREADY;
        m1_AWREADY = w_xfer & wgrant_q & ~aw_done_q & s0_AWREADY;
        m0_WREADY  = w_xfer & ~wgrant_q & ~w_done_q & s0_WREADY;
        m1_WREADY  = w_xfer & wgrant_q & ~w_done_q & s0_WREADY;
        m0_BVALID  = w_resp & ~wgrant_q & s0_BVALID;
        m1_BVALID  = w_resp & wgrant_q & s0_BVALID;
        m0_BRESP   = (w_resp & ~wgrant_q) ? s0_BRESP : 2'b00;
        m1_BRESP   = (w_resp & wgrant_q) ? s0_BRESP : 2'b00;
    end

    always_comb begin
        rstate_d = rstate_q;
        rgrant_d = rgrant_q;
        rprio_d  = rprio_q;
        case (rstate_q)
            R_IDLE: if (m0_ARVALID | m1_ARVALID) begin
                rstate_d = R_ADDR;
                rgrant_d = (m0_ARVALID & m1_ARVALID) ? rprio_q : m1_ARVALID;
            end
            R_ADDR: if (s0_ARVALID & s0_ARREADY) rstate_d = R_DATA;
            R_DATA: if (s0_RVALID & s0_RREADY) begin
                rstate_d = R_IDLE;
                rprio_d  = ~rgrant_q;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        r_addr     = rstate_q == R_ADDR;
        r_data     = rstate_q == R_DATA;
        s0_ARVALID = r_addr & (rgrant_q ? m1_ARVALID : m0_ARVALID);
        s0_ARADDR  = r_addr ? (rgrant_q ? m1_ARADDR : m0_ARADDR) : '0;
        s0_RREADY  = r_data & (rgrant_q ? m1_RREADY : m0_RREADY);
        m0_ARREADY = r_addr & ~rgrant_q & s0_ARREADY;
        m1_ARREADY = r_addr & rgrant_q & s0_ARREADY;
        m0_RVALID  = r_data & ~rgrant_q & s0_RVALID;
        m1_RVALID  = r_data & rgrant_q & s0_RVALID;
        m0_RRESP   = (r_data & ~rgrant_q) ? s0_RRESP : 2'b00;
        m1_RRESP   = (r_data & rgrant_q) ? s0_RRESP : 2'b00;
        m0_RDATA   = (r_data & ~rgrant_q) ? s0_RDATA : '0;
        m1_RDATA   = (r_data & rgrant_q) ? s0_RDATA : '0;
    end
endmodule

// File: tb/tb_axi4_lite_interconnect_m2s1.sv
// tb_axi4_lite_interconnect_m2s1: directed tests of the 2-master/1-slave
// AXI4-Lite interconnect against a small reactive slave.
module tb_axi4_lite_interconnect_m2s1;
    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    logic        m_awv [2];
    logic [31:0] m_awa [2];
    logic        m_wv  [2];
    logic [31:0] m_wd  [2];
    logic [3:0]  m_ws  [2];
    logic        m_br  [2];
    logic        m_arv [2];
    logic [31:0] m_ara [2];
    logic        m_rr  [2];

    logic m0_AWREADY, m0_WREADY, m0_BVALID, m0_ARREADY, m0_RVALID;
    logic m1_AWREADY, m1_WREADY, m1_BVALID, m1_ARREADY, m1_RVALID;
    logic [1:0] m0_BRESP, m0_RRESP, m1_BRESP, m1_RRESP;
    logic [31:0] m0_RDATA, m1_RDATA;
    logic s0_AWVALID, s0_WVALID, s0_BREADY, s0_ARVALID, s0_RREADY;
    logic [31:0] s0_AWADDR, s0_WDATA, s0_ARADDR;
    logic [3:0] s0_WSTRB;

    logic        w_rdy = 1'b1;
    logic        slv_rst = 1'b1;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;
    logic        saw, sw, s_bv, s_rv;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    int cyc = 0;
    int last0 = -1, last1 = -1;
    int passed = 0, total = 0;

    axi4_lite_interconnect_m2s1 dut (
        .iCLK(iCLK), .iRST(iRST),
        .m0_AWVALID(m_awv[0]), .m0_AWADDR(m_awa[0]), .m0_AWREADY(m0_AWREADY),
        .m0_WVALID(m_wv[0]), .m0_WDATA(m_wd[0]), .m0_WSTRB(m_ws[0]), .m0_WREADY(m0_WREADY),
        .m0_BREADY(m_br[0]), .m0_BVALID(m0_BVALID), .m0_BRESP(m0_BRESP),
        .m0_ARVALID(m_arv[0]), .m0_ARADDR(m_ara[0]), .m0_ARREADY(m0_ARREADY),
        .m0_RREADY(m_rr[0]), .m0_RVALID(m0_RVALID), .m0_RRESP(m0_RRESP), .m0_RDATA(m0_RDATA),
        .m1_AWVALID(m_awv[1]), .m1_AWADDR(m_awa[1]), .m1_AWREADY(m1_AWREADY),
        .m1_WVALID(m_wv[1]), .m1_WDATA(m_wd[1]), .m1_WSTRB(m_ws[1]), .m1_WREADY(m1_WREADY),
        .m1_BREADY(m_br[1]), .m1_BVALID(m1_BVALID), .m1_BRESP(m1_BRESP),
        .m1_ARVALID(m_arv[1]), .m1_ARADDR(m_ara[1]), .m1_ARREADY(m1_ARREADY),
        .m1_RREADY(m_rr[1]), .m1_RVALID(m1_RVALID), .m1_RRESP(m1_RRESP), .m1_RDATA(m1_RDATA),
        .s0_AWVALID(s0_AWVALID), .s0_AWADDR(s0_AWADDR), .s0_AWREADY(1'b1),
        .s0_WVALID(s0_WVALID), .s0_WDATA(s0_WDATA), .s0_WSTRB(s0_WSTRB), .s0_WREADY(w_rdy),
        .s0_BREADY(s0_BREADY), .s0_BVALID(s_bv), .s0_BRESP(bresp_cfg),
        .s0_ARVALID(s0_ARVALID), .s0_ARADDR(s0_ARADDR), .s0_ARREADY(1'b1),
        .s0_RREADY(s0_RREADY), .s0_RVALID(s_rv), .s0_RRESP(rresp_cfg), .s0_RDATA(rdata_cfg)
    );

    // Slave: BVALID one cycle after both AW and W are taken; RVALID right after AR.
    always @(posedge iCLK) begin
        cyc <= cyc + 1;
        if (slv_rst) begin
            saw <= 1'b0; sw <= 1'b0; s_bv <= 1'b0; s_rv <= 1'b0;
        end else begin
            if (s0_AWVALID) begin saw <= 1'b1; cap_awaddr <= s0_AWADDR; end
            if (s0_WVALID && w_rdy) begin sw <= 1'b1; cap_wdata <= s0_WDATA; cap_wstrb <= s0_WSTRB; end
            if (s_bv && s0_BREADY) s_bv <= 1'b0;
            else if (saw && sw) begin s_bv <= 1'b1; saw <= 1'b0; sw <= 1'b0; end
            if (s0_ARVALID) begin s_rv <= 1'b1; cap_araddr <= s0_ARADDR; end
            else if (s_rv && s0_RREADY) s_rv <= 1'b0;
        end
    end

    always @(posedge iCLK) begin
        #1;
        if (m0_AWREADY | m0_WREADY | m0_BVALID | (|m0_BRESP) | m0_ARREADY | m0_RVALID | (|m0_RRESP) | (|m0_RDATA)) last0 = cyc;
        if (m1_AWREADY | m1_WREADY | m1_BVALID | (|m1_BRESP) | m1_ARREADY | m1_RVALID | (|m1_RRESP) | (|m1_RDATA)) last1 = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic awr(input int m); return m ? m1_AWREADY : m0_AWREADY; endfunction
    function automatic logic wr(input int m); return m ? m1_WREADY : m0_WREADY; endfunction
    function automatic logic bv(input int m); return m ? m1_BVALID : m0_BVALID; endfunction
    function automatic logic [1:0] brsp(input int m); return m ? m1_BRESP : m0_BRESP; endfunction
    function automatic logic arr(input int m); return m ? m1_ARREADY : m0_ARREADY; endfunction
    function automatic logic rv(input int m); return m ? m1_RVALID : m0_RVALID; endfunction
    function automatic logic [1:0] rrsp(input int m); return m ? m1_RRESP : m0_RRESP; endfunction
    function automatic logic [31:0] rdat(input int m); return m ? m1_RDATA : m0_RDATA; endfunction

    task automatic clear_masters();
        for (int i = 0; i < 2; i++) begin
            m_awv[i] = 0; m_awa[i] = 0; m_wv[i] = 0; m_wd[i] = 0; m_ws[i] = 0;
            m_br[i] = 0; m_arv[i] = 0; m_ara[i] = 0; m_rr[i] = 0;
        end
    endtask

    task automatic reset_dut();
        @(negedge iCLK);
        iRST = 1; slv_rst = 1;
        clear_masters();
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 0; slv_rst = 0;
    endtask

    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            output logic [1:0] r, output int t);
        int n;
        logic ha, hw, hb;
        @(negedge iCLK);
        m_awv[m] = 1; m_awa[m] = a; m_wv[m] = 1; m_wd[m] = d; m_ws[m] = 4'hF; m_br[m] = 1;
        n = 0; hb = 0; r = 2'bxx;
        while ((m_awv[m] || m_wv[m]) && n < 100) begin
            #1;
            ha = m_awv[m] && awr(m);
            hw = m_wv[m] && wr(m);
            @(negedge iCLK);
            n++;
            if (ha) m_awv[m] = 0;
            if (hw) m_wv[m] = 0;
        end
        while (!hb && n < 100) begin
            #1;
            hb = bv(m);
            if (hb) r = brsp(m);
            @(negedge iCLK);
            n++;
        end
        m_awv[m] = 0; m_wv[m] = 0; m_br[m] = 0;
        t = cyc;
        check("wr_done", hb, 1);
    endtask

    task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output int t);
        int n;
        logic ha, hr;
        @(negedge iCLK);
        m_arv[m] = 1; m_ara[m] = a; m_rr[m] = 1;
        n = 0; hr = 0; d = 'x; r = 2'bxx;
        while (m_arv[m] && n < 100) begin
            #1;
            ha = arr(m);
            @(negedge iCLK);
            n++;
            if (ha) m_arv[m] = 0;
        end
        while (!hr && n < 100) begin
            #1;
            hr = rv(m);
            if (hr) begin d = rdat(m); r = rrsp(m); end
            @(negedge iCLK);
            n++;
        end
        m_arv[m] = 0; m_rr[m] = 0;
        t = cyc;
        check("rd_done", hr, 1);
    endtask

    initial begin
        logic [1:0] r0, r1;
        logic [31:0] d;
        int t0, t1, t2, s;
        clear_masters();
        reset_dut();
        #1;
        check("rst_s0", {s0_AWVALID, s0_WVALID, s0_BREADY, s0_ARVALID, s0_RREADY}, 0);
        check("rst_s0_addr", s0_AWADDR | s0_ARADDR | s0_WDATA, 0);
        check("rst_m0", {m0_AWREADY, m0_WREADY, m0_BVALID, m0_ARREADY, m0_RVALID}, 0);
        check("rst_m1", {m1_AWREADY, m1_WREADY, m1_BVALID, m1_ARREADY, m1_RVALID}, 0);

        // single master write, one-cycle arbitration latency
        s = cyc;
        fork
            do_write(0, 32'h10, 32'hDEADBEEF, r0, t0);
            begin
                @(negedge iCLK); #1;
                check("lat_pre_awvalid", s0_AWVALID, 0);
                @(posedge iCLK); #1;
                check("lat_awvalid", s0_AWVALID, 1);
                check("lat_awaddr", s0_AWADDR, 32'h10);
                check("lat_wdata", s0_WDATA, 32'hDEADBEEF);
            end
        join
        check("w_cap_addr", cap_awaddr, 32'h10);
        check("w_cap_data", cap_wdata, 32'hDEADBEEF);
        check("w_cap_strb", cap_wstrb, 4'hF);
        check("w_bresp", r0, 2'b00);
        check("w_m1_quiet", last1 < s, 1);

        // round robin: m0 first after reset, held-off m1 next, then alternation
        reset_dut();
        fork
            begin
                do_write(0, 32'h100, 32'hA0, r0, t0);
                do_write(0, 32'h104, 32'hA1, r0, t2);
            end
            do_write(1, 32'h200, 32'hB0, r1, t1);
        join
        check("rr_m0_first", t0 < t1, 1);
        check("rr_m1_second", t1 < t2, 1);
        fork
            do_write(0, 32'h108, 32'hA2, r0, t0);
            do_write(1, 32'h208, 32'hB2, r1, t1);
        join
        check("rr_alt_m1_first", t1 < t0, 1);
        check("rr_last_data", cap_wdata, 32'hA2);

        // concurrent write (m1) and read (m0)
        reset_dut();
        rdata_cfg = 32'h12345678;
        fork
            do_write(1, 32'h300, 32'hCAFE0001, r1, t1);
            do_read(0, 32'h40, d, r0, t0);
            begin
                @(negedge iCLK); @(posedge iCLK); #1;
                check("conc_both_valid", {s0_AWVALID, s0_ARVALID}, 2'b11);
            end
        join
        check("conc_rdata", d, 32'h12345678);
        check("conc_rresp", r0, 2'b00);
        check("conc_araddr", cap_araddr, 32'h40);
        check("conc_wdata", cap_wdata, 32'hCAFE0001);
        check("conc_bresp", r1, 2'b00);

        // slave stalls WREADY for three cycles after AW is accepted
        reset_dut();
        w_rdy = 0;
        fork
            do_write(0, 32'h500, 32'h55AA55AA, r0, t0);
            begin
                @(negedge iCLK); @(posedge iCLK); #1;
                check("stall_aw_first", s0_AWVALID, 1);
                for (int i = 0; i < 3; i++) begin
                    @(posedge iCLK); #1;
                    check("stall_aw_low", s0_AWVALID, 0);
                    check("stall_wvalid", s0_WVALID, 1);
                    check("stall_m0_wready", m0_WREADY, 0);
                    check("stall_m0_bvalid", m0_BVALID, 0);
                end
                @(negedge iCLK);
                w_rdy = 1;
            end
        join
        check("stall_data", cap_wdata, 32'h55AA55AA);
        check("stall_bresp", r0, 2'b00);

        // reset while a write response is pending
        reset_dut();
        bresp_cfg = 2'b01;
        do_write(0, 32'h600, 32'h1, r0, t0);
        @(negedge iCLK);
        m_awv[0] = 1; m_awa[0] = 32'h604; m_wv[0] = 1; m_wd[0] = 32'h2; m_ws[0] = 4'hF; m_br[0] = 0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        m_awv[0] = 0; m_wv[0] = 0;
        @(posedge iCLK); #1;
        check("abort_pre_bvalid", m0_BVALID, 1);
        check("abort_pre_bresp", m0_BRESP, 2'b01);
        @(negedge iCLK);
        iRST = 1;
        @(posedge iCLK); #1;
        check("abort_bvalid", {m0_BVALID, m1_BVALID}, 0);
        check("abort_bresp", {m0_BRESP, m1_BRESP}, 0);
        check("abort_bready", s0_BREADY, 0);
        @(negedge iCLK);
        iRST = 0; slv_rst = 1;
        @(negedge iCLK);
        slv_rst = 0;
        bresp_cfg = 2'b00;
        fork
            do_write(0, 32'h610, 32'h3, r0, t0);
            do_write(1, 32'h614, 32'h4, r1, t1);
        join
        check("abort_prio_m0", t0 < t1, 1);

        // error responses pass through unmodified
        reset_dut();
        bresp_cfg = 2'b10; rresp_cfg = 2'b11; rdata_cfg = 32'hA5A50033;
        s = cyc;
        fork
            do_write(1, 32'h700, 32'h77, r1, t1);
            do_read(1, 32'h704, d, r0, t0);
        join
        check("err_bresp", r1, 2'b10);
        check("err_rresp", r0, 2'b11);
        check("err_rdata", d, 32'hA5A50033);
        check("err_m0_quiet", last0 < s, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi4_lite_interconnect_m2s1.md
AXI4_LITE_INTERCONNECT_M2S1 -- requirements
Module: axi4_lite_interconnect_m2s1

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all AWADDR/ARADDR ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of all WDATA/RDATA ports; WSTRB width is DATA_WIDTH/8.
REQ-003 iCLK  in  1  single clock; all state changes on rising edge.
REQ-004 iRST  in  1  reset, synchronous, active-high.
REQ-005 For N in {0,1}, mN_AWVALID/mN_AWADDR  in  1/ADDR_WIDTH; mN_AWREADY  out  1  master N write address.
REQ-006 mN_WVALID/mN_WDATA/mN_WSTRB  in  1/DATA_WIDTH/DATA_WIDTH/8; mN_WREADY  out  1  master N write data.
REQ-007 mN_BREADY  in  1; mN_BVALID/mN_BRESP  out  1/2  master N write response.
REQ-008 mN_ARVALID/mN_ARADDR  in  1/ADDR_WIDTH; mN_ARREADY  out  1  master N read address.
REQ-009 mN_RREADY  in  1; mN_RVALID/mN_RRESP/mN_RDATA  out  1/2/DATA_WIDTH  master N read data.
REQ-010 s0_AWVALID/s0_AWADDR, s0_WVALID/s0_WDATA/s0_WSTRB, s0_BREADY, s0_ARVALID/s0_ARADDR, s0_RREADY  out; widths as master side.
REQ-011 s0_AWREADY, s0_WREADY, s0_BVALID/s0_BRESP, s0_ARREADY, s0_RVALID/s0_RRESP/s0_RDATA  in; widths as master side.

Function
REQ-012 Write path and read path shall each have an independent arbiter and FSM; one write and one read may be in flight concurrently, to the same or different masters.
REQ-013 Write FSM states: W_IDLE, W_XFER, W_RESP.
REQ-014 W_IDLE: at a rising edge with any mN_AWVALID=1, latch wgrant and move to W_XFER; only one master requesting -> grant it; both -> grant the master indicated by round-robin pointer wprio.
REQ-015 W_XFER: granted master's AW and W channels routed combinationally to s0 (VALID, ADDR/DATA/STRB forward; READY back); AW and W handshakes tracked by aw_done/w_done flags, each channel's VALID to s0 deasserted after its handshake.
REQ-016 W_XFER -> W_RESP at the edge where both handshakes have completed (same-cycle completion of both allowed).
REQ-017 W_RESP: s0_BVALID/s0_BRESP routed to granted master, its mN_BREADY routed to s0_BREADY; at edge with s0_BVALID && s0_BREADY -> W_IDLE, wprio set to the non-granted master, flags cleared.
REQ-018 Read FSM states: R_IDLE, R_ADDR, R_DATA; arbitration identical to REQ-014 using mN_ARVALID and pointer rprio.
REQ-019 R_ADDR routes AR of granted master; at s0_ARVALID && s0_ARREADY -> R_DATA.
REQ-020 R_DATA routes RVALID/RRESP/RDATA to granted master, RREADY back; at s0_RVALID && s0_RREADY -> R_IDLE, rprio set to the non-granted master.
REQ-021 Arbitration latency: exactly one cycle; request sampled at edge k gives s0_AWVALID/s0_ARVALID=1 in the cycle after edge k.
REQ-022 Non-granted master, and both masters while FSM idle: all READY and VALID outputs 0, RESP 0, RDATA 0.
REQ-023 s0 outputs while no grant on that path: VALID/READY 0, ADDR/DATA/STRB 0.
REQ-024 A request arriving while the path is busy shall be held off (READY=0) and considered at the next IDLE edge; no request dropped.
REQ-025 No address decode and no response generation: RESP values pass through unmodified.

Reset
REQ-026 iRST=1 at a rising edge: both FSMs to IDLE, aw_done/w_done cleared, wprio=rprio=master 0, grants cleared.
REQ-027 Reset mid-transaction aborts it: from the next cycle all VALID/READY outputs 0, all RESP/DATA outputs 0, no completion reported to any master.

Verification
REQ-028 m0 write 0x10=0xDEADBEEF alone -> s0_AWADDR=0x10, s0_WDATA=0xDEADBEEF; m0_BVALID=1, BRESP=00; m1 outputs all 0.
REQ-029 m0 and m1 AWVALID same edge after reset -> m0 served first, m1 served next; then simultaneous again -> m0 served after m1 (alternation).
REQ-030 m1 write and m0 read issued same cycle -> both complete concurrently, data 0x12345678 returned on m0_RDATA with RRESP=00.
REQ-031 Slave holds s0_WREADY=0 three cycles after AW accepted -> m0_WREADY low, FSM stays W_XFER, completes once WREADY=1; s0 AWVALID not reasserted.
REQ-032 iRST=1 during W_RESP with s0_BVALID pending -> next cycle all master BVALID 0, FSM W_IDLE, wprio=m0.
REQ-033 Slave returns BRESP=10 and RRESP=11 -> same values delivered to granted master unmodified.
